wb_regfile: RTL
===============

Name: wb_regfile

Overview:
- Write-back stage plus architectural register file; consumes the MEM/WB pipeline register outputs.
- Selects the write-back value (ALU result or loaded memory word) and commits it to a 2**ADDR_W x DATA_W register file on the clock edge.
- Serves the two ID-stage read ports (rs/rt) and exposes the write-back value to the forwarding unit.
- Keeps a saturating count of committed writes for bring-up/debug.

Parameters:
- DATA_W, 32, register and data width in bits
- ADDR_W, 5, register index width; register count = 2**ADDR_W
- COUNT_W, 32, width of the committed-write counter

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- alu_res_in  input  DATA_W  ALU result from the MEM/WB register
- mem_word_in  input  DATA_W  loaded memory word from the MEM/WB register
- wb_dst_in  input  ADDR_W  destination register index (rs/rt/rd already resolved upstream)
- wb_src_in  input  1  1 = write back mem_word_in, 0 = write back alu_res_in
- wb_write_in  input  1  register write enable
- rs_addr  input  ADDR_W  read port A index (ID stage)
- rt_addr  input  ADDR_W  read port B index (ID stage)
- rs_data  output  DATA_W  read port A data
- rt_data  output  DATA_W  read port B data
- wb_data  output  DATA_W  selected write-back value, to forwarding unit
- wb_count  output  COUNT_W  number of committed writes, saturating

Behaviour:
- Reset: rst_n low clears all registers to 0 and wb_count to 0 immediately, independent of clk. While rst_n is low, no write commits. Reset asserted mid-cycle discards any pending write.
- Write-back mux (combinational, zero latency): wb_data = wb_src_in ? mem_word_in : alu_res_in. wb_data is valid whether or not wb_write_in is set.
- Commit: on rising clk with rst_n high, wb_write_in = 1 and wb_dst_in != 0: reg[wb_dst_in] <= wb_data.
- Register 0 is hardwired to zero.
  - Writes to index 0 are dropped and are not counted.
  - Reads of index 0 always return 0.
- Reads are asynchronous (combinational from rs_addr/rt_addr). Both ports may address the same register.
- Read during write, same cycle, without bypass: the read returns the old value. The new value is visible from the cycle after the commit edge.
- Counter: on each commit edge that actually writes (wb_write_in = 1, wb_dst_in != 0), wb_count <= wb_count + 1.
  - At all-ones, wb_count holds (saturates); it never wraps.
- X on wb_write_in is not tolerated. The bench treats it as an error. No special RTL handling is required.
- No handshake. The stage accepts one instruction per cycle and never stalls. Stalls and bubbles upstream arrive as wb_write_in = 0.

Optional Feature:
- Macro: WB_REGFILE_BYPASS_EN.
- Defined: internal write-to-read bypass.
  - If wb_write_in = 1, wb_dst_in != 0 and rs_addr == wb_dst_in, then rs_data = wb_data in the same cycle. Same rule for rt_addr/rt_data.
  - Index 0 still reads 0.
  - Removes the need for a split-phase register file in the 5-stage hazard scheme.
- Undefined: no bypass. Reads return stored contents only. The hazard unit must stall one extra cycle or forward externally using wb_data.

Test Plan:
- Reset: drive rst_n = 0 mid-cycle after writing reg 5 = 0x1234_5678 -> rs_data for reg 5 reads 0 and wb_count = 0 without waiting for a clk edge.
- Mux/commit:
  - wb_src_in = 0, alu_res_in = 0xDEAD_BEEF, mem_word_in = 0x0BAD_F00D, wb_dst_in = 8, wb_write_in = 1 -> wb_data = 0xDEAD_BEEF; after the edge, rs_addr = 8 reads 0xDEAD_BEEF and wb_count = 1.
  - Repeat with wb_src_in = 1 and wb_dst_in = 9 -> reg 9 = 0x0BAD_F00D and wb_count = 2.
- Zero register: write 0xFFFF_FFFF to index 0 with wb_write_in = 1 -> rs_data/rt_data at index 0 stay 0 and wb_count is unchanged. wb_write_in = 0 with wb_dst_in = 3 -> reg 3 is unchanged.
- Read-during-write: reg 4 = 0x11; in the same cycle write 0x22 to reg 4 with rs_addr = rt_addr = 4.
  - With WB_REGFILE_BYPASS_EN: both ports read 0x22 before the edge.
  - Without it: both read 0x11 before the edge and 0x22 after.
- Counter saturation: with COUNT_W = 4, perform 20 committed writes -> wb_count reaches 15 and holds at 15.
- Back-to-back: write regs 1..31 on consecutive cycles with value = index * 0x0101_0101, then read all pairs (i, 32-i) -> every value matches and wb_count = 31.

Source files
------------

// File: rtl/wb_regfile.sv
// wb_regfile: write-back stage and architectural register file.
// Selects the write-back value (ALU result or loaded word), commits it to a
// 2**ADDR_W x DATA_W register file and serves two asynchronous read ports.
// It also keeps a saturating count of committed writes for bring-up.
// Register 0 is hardwired to zero.
// Optional macro WB_REGFILE_BYPASS_EN adds a same-cycle write-to-read bypass
// on both read ports. Without it, reads return only the stored contents.
module wb_regfile #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int COUNT_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [DATA_W-1:0]  alu_res_in,
    input  logic [DATA_W-1:0]  mem_word_in,
    input  logic [ADDR_W-1:0]  wb_dst_in,
    input  logic               wb_src_in,
    input  logic               wb_write_in,
    input  logic [ADDR_W-1:0]  rs_addr,
    input  logic [ADDR_W-1:0]  rt_addr,
    output logic [DATA_W-1:0]  rs_data,
    output logic [DATA_W-1:0]  rt_data,
    output logic [DATA_W-1:0]  wb_data,
    output logic [COUNT_W-1:0] wb_count
);

    localparam int NUM_REGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic              commit;

    // The write-back mux is valid regardless of the write enable, so the
    // forwarding unit can always use it.
    assign wb_data = wb_src_in ? mem_word_in : alu_res_in;

    // A write takes effect only for a non-zero destination. Writes to
    // register 0 are dropped and are not counted.
    assign commit  = wb_write_in && (wb_dst_in != '0);

    // Commit the write-back value into the register file.
    // NOTE: the array is reset element by element because its contents must
    // read as zero right after reset. That makes it a bank of flops and not
    // an inferable RAM, which is intended at this size.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (commit) begin
            // NOTE: non-blocking, so combinational reads this cycle still see the old value.
            regs[wb_dst_in] <= wb_data;
        end
    end

    // Saturating count of writes that actually landed in the register file.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_count <= '0;
        end else if (commit && (wb_count != '1)) begin
            wb_count <= wb_count + 1'b1;
        end
    end

    // Asynchronous read ports. Index 0 always reads zero. When the bypass is
    // built in, the value being written this cycle is forwarded.
    always_comb begin
        // NOTE: defaults first, so every path assigns and no latch is inferred.
        rs_data = regs[rs_addr];
        rt_data = regs[rt_addr];
`ifdef WB_REGFILE_BYPASS_EN
        if (commit && (rs_addr == wb_dst_in)) begin
            rs_data = wb_data;
        end
        if (commit && (rt_addr == wb_dst_in)) begin
            rt_data = wb_data;
        end
`endif
        if (rs_addr == '0) begin
            rs_data = '0;
        end
        if (rt_addr == '0) begin
            rt_data = '0;
        end
    end

endmodule
